// File: rtl/i2c_bridge_pkg.sv
// i2c_bridge_pkg: byte width, handshake FSM states, timer width helper
// for the I2C host FIFO bridge. No ports.
package i2c_bridge_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_HOLD = 1'b1
  } tx_state_e;

  typedef enum logic {
    RX_IDLE = 1'b0,
    RX_HOLD = 1'b1
  } rx_state_e;

  // Timer counts 0..timeout-1 while a handshake is held.
  function automatic int hs_tmr_w(input int timeout);
    return (timeout < 2) ? 1 : $clog2(timeout);
  endfunction

endpackage

// File: rtl/i2c_host_fifo_bridge_if.sv
// i2c_host_fifo_bridge_if: bridge <-> I2C controller byte handshake.
// master = bridge side, slave = controller side.
interface i2c_host_fifo_bridge_if;
  import i2c_bridge_pkg::*;

  logic [BYTE_W-1:0] byte_wr_o;
  logic              wr_rdy_o;
  logic              wr_reg_empty_i;
  logic [BYTE_W-1:0] byte_rd_i;
  logic              rd_clr_o;
  logic              rd_reg_full_i;

  modport master (
    output byte_wr_o,
    output wr_rdy_o,
    output rd_clr_o,
    input  wr_reg_empty_i,
    input  byte_rd_i,
    input  rd_reg_full_i
  );

  modport slave (
    input  byte_wr_o,
    input  wr_rdy_o,
    input  rd_clr_o,
    output wr_reg_empty_i,
    output byte_rd_i,
    output rd_reg_full_i
  );

endinterface

// File: rtl/i2c_sync_fifo.sv
// i2c_sync_fifo: registered FWFT FIFO. push/pop/flush in; data_o (head),
// full/empty/count out; ovf_o/udf_o pulse on a refused push/pop.
module i2c_sync_fifo
  import i2c_bridge_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = BYTE_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   ovf_o,
  output logic                   udf_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wp_q;
  logic [AW-1:0]    rp_q;
  logic [AW:0]      cnt_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == FULL_CNT);
  assign count_o = cnt_q;
  assign data_o  = mem_q[rp_q];

  // Pop is resolved first, so a full FIFO can take push+pop together.
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign do_push = push_i && (!full_o || do_pop) && !flush_i;
  assign ovf_o   = push_i && !flush_i && !do_push;
  assign udf_o   = pop_i && !flush_i && empty_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wp_q] <= data_i;
        wp_q        <= wp_q + AW'(1);
      end
      if (do_pop) begin
        rp_q <= rp_q + AW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/i2c_host_fifo_bridge.sv
// i2c_host_fifo_bridge: host TX/RX byte FIFOs + level handshakes to the
// I2C controller (ctrl). Host: tx_push/tx_data/tx_full, rx_pop/rx_data/
// rx_empty, err_clr, sticky tx_ovf/rx_udf/hs_err.
// I2C_BRIDGE_LEVEL_EN adds tx_level/rx_level occupancy outputs.
module i2c_host_fifo_bridge
  import i2c_bridge_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int HS_TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              tx_push,
  input  logic [BYTE_W-1:0] tx_data,
  output logic              tx_full,
  input  logic              rx_pop,
  output logic [BYTE_W-1:0] rx_data,
  output logic              rx_empty,
  input  logic              err_clr,
  output logic              tx_ovf,
  output logic              rx_udf,
  output logic              hs_err,
`ifdef I2C_BRIDGE_LEVEL_EN
  output logic [$clog2(DEPTH):0] tx_level,
  output logic [$clog2(DEPTH):0] rx_level,
`endif
  i2c_host_fifo_bridge_if.master ctrl
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = hs_tmr_w(HS_TIMEOUT);
  localparam logic [TW-1:0] TO_LAST = TW'(HS_TIMEOUT - 1);

  logic [BYTE_W-1:0] tx_head;
  logic              tx_empty;
  logic              tx_pop;
  logic [CW-1:0]     tx_cnt;
  logic              tx_ovf_p;
  logic              tx_udf_p;

  logic              rx_full;
  logic              rx_push;
  logic [CW-1:0]     rx_cnt;
  logic              rx_ovf_p;
  logic              rx_udf_p;

  tx_state_e         tx_state_q, tx_state_d;
  logic [TW-1:0]     tx_tmr_q, tx_tmr_d;
  logic [BYTE_W-1:0] byte_wr_q, byte_wr_d;
  logic              wr_rdy_q, wr_rdy_d;
  logic              tx_arm_q, tx_arm_d;
  logic              tx_to;

  rx_state_e         rx_state_q, rx_state_d;
  logic [TW-1:0]     rx_tmr_q, rx_tmr_d;
  logic              rd_clr_q, rd_clr_d;
  logic              rx_arm_q, rx_arm_d;
  logic              rx_to;

  logic              tx_ovf_q, tx_ovf_d;
  logic              rx_udf_q, rx_udf_d;
  logic              hs_err_q, hs_err_d;

  i2c_sync_fifo #(.DEPTH(DEPTH), .WIDTH(BYTE_W)) u_tx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush),
    .push_i  (tx_push),
    .data_i  (tx_data),
    .pop_i   (tx_pop),
    .data_o  (tx_head),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .count_o (tx_cnt),
    .ovf_o   (tx_ovf_p),
    .udf_o   (tx_udf_p)
  );

  i2c_sync_fifo #(.DEPTH(DEPTH), .WIDTH(BYTE_W)) u_rx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush),
    .push_i  (rx_push),
    .data_i  (ctrl.byte_rd_i),
    .pop_i   (rx_pop),
    .data_o  (rx_data),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .count_o (rx_cnt),
    .ovf_o   (rx_ovf_p),
    .udf_o   (rx_udf_p)
  );

  // Arm flags demand a low->high cycle of the controller status before
  // the next transfer, so a timed-out handshake is never replayed.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_tmr_d   = tx_tmr_q;
    byte_wr_d  = byte_wr_q;
    wr_rdy_d   = wr_rdy_q;
    tx_arm_d   = tx_arm_q | ~ctrl.wr_reg_empty_i;
    tx_pop     = 1'b0;
    tx_to      = 1'b0;
    unique case (tx_state_q)
      TX_IDLE: begin
        if (ctrl.wr_reg_empty_i && tx_arm_q && !tx_empty) begin
          byte_wr_d  = tx_head;
          tx_pop     = 1'b1;
          wr_rdy_d   = 1'b1;
          tx_tmr_d   = '0;
          tx_state_d = TX_HOLD;
        end
      end
      TX_HOLD: begin
        if (!ctrl.wr_reg_empty_i) begin
          wr_rdy_d   = 1'b0;
          tx_state_d = TX_IDLE;
        end else if (tx_tmr_q == TO_LAST) begin
          wr_rdy_d   = 1'b0;
          tx_to      = 1'b1;
          tx_arm_d   = 1'b0;
          tx_state_d = TX_IDLE;
        end else if (tx_tmr_q != '1) begin
          tx_tmr_d = tx_tmr_q + TW'(1);
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
    if (flush) begin
      tx_state_d = TX_IDLE;
      tx_tmr_d   = '0;
      byte_wr_d  = '0;
      wr_rdy_d   = 1'b0;
      tx_arm_d   = 1'b1;
      tx_pop     = 1'b0;
      tx_to      = 1'b0;
    end
  end

  // A full RX FIFO simply leaves the controller's byte unclaimed, which
  // makes the controller stretch SCL; no timer runs while stalled.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_tmr_d   = rx_tmr_q;
    rd_clr_d   = rd_clr_q;
    rx_arm_d   = rx_arm_q | ~ctrl.rd_reg_full_i;
    rx_push    = 1'b0;
    rx_to      = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        if (ctrl.rd_reg_full_i && rx_arm_q && !rx_full) begin
          rx_push    = 1'b1;
          rd_clr_d   = 1'b1;
          rx_tmr_d   = '0;
          rx_state_d = RX_HOLD;
        end
      end
      RX_HOLD: begin
        if (!ctrl.rd_reg_full_i) begin
          rd_clr_d   = 1'b0;
          rx_state_d = RX_IDLE;
        end else if (rx_tmr_q == TO_LAST) begin
          rd_clr_d   = 1'b0;
          rx_to      = 1'b1;
          rx_arm_d   = 1'b0;
          rx_state_d = RX_IDLE;
        end else if (rx_tmr_q != '1) begin
          rx_tmr_d = rx_tmr_q + TW'(1);
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
    if (flush) begin
      rx_state_d = RX_IDLE;
      rx_tmr_d   = '0;
      rd_clr_d   = 1'b0;
      rx_arm_d   = 1'b1;
      rx_push    = 1'b0;
      rx_to      = 1'b0;
    end
  end

  // A new error in the same cycle as err_clr keeps the flag set.
  always_comb begin
    tx_ovf_d = tx_ovf_q;
    rx_udf_d = rx_udf_q;
    hs_err_d = hs_err_q;
    if (flush) begin
      tx_ovf_d = 1'b0;
      rx_udf_d = 1'b0;
      hs_err_d = 1'b0;
    end else begin
      if (tx_ovf_p)            tx_ovf_d = 1'b1;
      else if (err_clr)        tx_ovf_d = 1'b0;
      if (rx_udf_p)            rx_udf_d = 1'b1;
      else if (err_clr)        rx_udf_d = 1'b0;
      if (tx_to || rx_to)      hs_err_d = 1'b1;
      else if (err_clr)        hs_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      tx_tmr_q   <= '0;
      byte_wr_q  <= '0;
      wr_rdy_q   <= 1'b0;
      tx_arm_q   <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_tmr_q   <= '0;
      rd_clr_q   <= 1'b0;
      rx_arm_q   <= 1'b1;
      tx_ovf_q   <= 1'b0;
      rx_udf_q   <= 1'b0;
      hs_err_q   <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_tmr_q   <= tx_tmr_d;
      byte_wr_q  <= byte_wr_d;
      wr_rdy_q   <= wr_rdy_d;
      tx_arm_q   <= tx_arm_d;
      rx_state_q <= rx_state_d;
      rx_tmr_q   <= rx_tmr_d;
      rd_clr_q   <= rd_clr_d;
      rx_arm_q   <= rx_arm_d;
      tx_ovf_q   <= tx_ovf_d;
      rx_udf_q   <= rx_udf_d;
      hs_err_q   <= hs_err_d;
    end
  end

  assign ctrl.byte_wr_o = byte_wr_q;
  assign ctrl.wr_rdy_o  = wr_rdy_q;
  assign ctrl.rd_clr_o  = rd_clr_q;
  assign tx_ovf         = tx_ovf_q;
  assign rx_udf         = rx_udf_q;
  assign hs_err         = hs_err_q;

  // TX pops are gated by !empty and RX pushes by !full, so those
  // FIFO error pulses cannot fire.
`ifdef I2C_BRIDGE_LEVEL_EN
  assign tx_level = tx_cnt;
  assign rx_level = rx_cnt;
  logic unused_ok;
  assign unused_ok = tx_udf_p ^ rx_ovf_p;
`else
  logic unused_ok;
  assign unused_ok = ^{tx_cnt, rx_cnt, tx_udf_p, rx_ovf_p};
`endif

endmodule
